decode_exec_unit: RTL and testbench

// - Main control decode, ALU-control decode and the 32-bit ALU of the 5-stage MIPS pipeline, in one block.
// - Decodes the ID-stage opcode into datapath controls and carries them through the ID/EX register.
// - Decodes aluop/funct in EX and executes the ALU on operands a/b/c supplied by the datapath forwarding/alusrc muxes.
// - Registers the result and zero flag into the EX/MEM register.

---
 rtl/mips_pkg.sv | 60 ++++++
 rtl/alu_core.sv | 41 ++++
 rtl/decode_exec_unit.sv | 161 ++++++++++++++++
 tb/tb_decode_exec_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID/EX control payload.
//   Opcode and funct encodings, the ALU-control codes and the aluop classes
//   used by decode_exec_unit and alu_core.
package mips_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned ALUCTL_W = 4;

  // Main opcodes (instruction [31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // R-type funct codes (instruction [5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [FUNCT_W-1:0] FN_ADD3 = 6'b000011;

  // aluop classes produced by the main decoder
  localparam logic [ALUOP_W-1:0] ALUOP_MEM    = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_INV    = 2'b11;

  // ALU operation codes
  localparam logic [ALUCTL_W-1:0] ALUCTL_AND  = 4'b0000;
  localparam logic [ALUCTL_W-1:0] ALUCTL_OR   = 4'b0001;
  localparam logic [ALUCTL_W-1:0] ALUCTL_ADD  = 4'b0010;
  localparam logic [ALUCTL_W-1:0] ALUCTL_ADD3 = 4'b0011;
  localparam logic [ALUCTL_W-1:0] ALUCTL_SUB  = 4'b0110;
  localparam logic [ALUCTL_W-1:0] ALUCTL_SLT  = 4'b0111;
  localparam logic [ALUCTL_W-1:0] ALUCTL_NOR  = 4'b1100;
  localparam logic [ALUCTL_W-1:0] ALUCTL_XOR  = 4'b1101;
  localparam logic [ALUCTL_W-1:0] ALUCTL_INV  = 4'b1111;

  // Datapath controls carried through the ID/EX register
  typedef struct packed {
    logic               regdst;
    logic               alusrc;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               regwrite;
    logic [ALUOP_W-1:0] aluop;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NOP = '0;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU.
//   ctl        : ALU operation code (ALUCTL_*)
//   a, b, c    : operands; c is only used by the three-input add
//   out        : result, modulo 2^WIDTH, unknown codes give 0
//   zero       : out == 0
module alu_core
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [ALUCTL_W-1:0] ctl,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    c,
  output logic [WIDTH-1:0]    out,
  output logic                zero
);

  logic lt;

  // Signed compare for slt; sign comes from bit WIDTH-1
  assign lt = $signed(a) < $signed(b);

  always_comb begin
    out = '0;
    case (ctl)
      ALUCTL_AND:  out = a & b;
      ALUCTL_OR:   out = a | b;
      ALUCTL_ADD:  out = a + b;
      ALUCTL_ADD3: out = a + b + c;
      ALUCTL_SUB:  out = a - b;
      ALUCTL_SLT:  out = WIDTH'(lt);
      ALUCTL_NOR:  out = ~(a | b);
      ALUCTL_XOR:  out = a ^ b;
      default:     out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/decode_exec_unit.sv
// Main control decode, ALU-control decode and ALU for the 5-stage MIPS pipe.
//   clk, rst_n          : clock, async active-low reset
//   stall, flush        : load-use bubble into EX / taken-branch clear
//   opcode, funct       : ID-stage instruction fields
//   a, b, c             : EX operands from the forwarding/alusrc muxes
//   branch_eq/ne, jump  : ID-stage combinational branch/jump decode
//   *_ex                : ID/EX registered controls
//   aluctl_ex, alu_out_ex : EX-stage combinational ALU control and result
//   result_mem, zero_mem  : EX/MEM registered result and zero flag
module decode_exec_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    c,
  output logic                branch_eq,
  output logic                branch_ne,
  output logic                jump,
  output logic                regdst_ex,
  output logic                alusrc_ex,
  output logic                memread_ex,
  output logic                memwrite_ex,
  output logic                memtoreg_ex,
  output logic                regwrite_ex,
  output logic [ALUCTL_W-1:0] aluctl_ex,
  output logic [WIDTH-1:0]    alu_out_ex,
  output logic [WIDTH-1:0]    result_mem,
  output logic                zero_mem
);

  ex_ctrl_t           ctrl_id;
  ex_ctrl_t           ctrl_ex;
  logic [FUNCT_W-1:0] funct_ex;
  logic               zero_ex;

  // Main control decode (ID stage)
  always_comb begin
    ctrl_id   = EX_CTRL_NOP;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_id.regdst   = 1'b1;
        ctrl_id.regwrite = 1'b1;
        ctrl_id.aluop    = ALUOP_RTYPE;
      end
      OP_LW: begin
        ctrl_id.alusrc   = 1'b1;
        ctrl_id.memread  = 1'b1;
        ctrl_id.memtoreg = 1'b1;
        ctrl_id.regwrite = 1'b1;
        ctrl_id.aluop    = ALUOP_MEM;
      end
      OP_SW: begin
        ctrl_id.alusrc   = 1'b1;
        ctrl_id.memwrite = 1'b1;
        ctrl_id.aluop    = ALUOP_MEM;
      end
      OP_ADDI: begin
        ctrl_id.alusrc   = 1'b1;
        ctrl_id.regwrite = 1'b1;
        ctrl_id.aluop    = ALUOP_MEM;
      end
      OP_BEQ: begin
        branch_eq     = 1'b1;
        ctrl_id.aluop = ALUOP_BRANCH;
      end
      OP_BNE: begin
        branch_ne     = 1'b1;
        ctrl_id.aluop = ALUOP_BRANCH;
      end
      OP_J: begin
        jump = 1'b1;
      end
      default: begin
        ctrl_id = EX_CTRL_NOP;
      end
    endcase
  end

  // ID/EX register: a stall bubbles the controls but keeps funct
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_ex  <= EX_CTRL_NOP;
      funct_ex <= '0;
    end else if (flush) begin
      ctrl_ex  <= EX_CTRL_NOP;
      funct_ex <= '0;
    end else if (stall) begin
      ctrl_ex  <= EX_CTRL_NOP;
    end else begin
      ctrl_ex  <= ctrl_id;
      funct_ex <= funct;
    end
  end

  assign regdst_ex   = ctrl_ex.regdst;
  assign alusrc_ex   = ctrl_ex.alusrc;
  assign memread_ex  = ctrl_ex.memread;
  assign memwrite_ex = ctrl_ex.memwrite;
  assign memtoreg_ex = ctrl_ex.memtoreg;
  assign regwrite_ex = ctrl_ex.regwrite;

  // ALU-control decode (EX stage)
  always_comb begin
    aluctl_ex = ALUCTL_INV;
    case (ctrl_ex.aluop)
      ALUOP_MEM:    aluctl_ex = ALUCTL_ADD;
      ALUOP_BRANCH: aluctl_ex = ALUCTL_SUB;
      ALUOP_RTYPE: begin
        case (funct_ex)
          FN_ADD:  aluctl_ex = ALUCTL_ADD;
          FN_SUB:  aluctl_ex = ALUCTL_SUB;
          FN_AND:  aluctl_ex = ALUCTL_AND;
          FN_OR:   aluctl_ex = ALUCTL_OR;
          FN_SLT:  aluctl_ex = ALUCTL_SLT;
          FN_NOR:  aluctl_ex = ALUCTL_NOR;
          FN_XOR:  aluctl_ex = ALUCTL_XOR;
          FN_ADD3: aluctl_ex = ALUCTL_ADD3;
          default: aluctl_ex = ALUCTL_INV;
        endcase
      end
      default:      aluctl_ex = ALUCTL_INV;
    endcase
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .ctl  (aluctl_ex),
    .a    (a),
    .b    (b),
    .c    (c),
    .out  (alu_out_ex),
    .zero (zero_ex)
  );

  // EX/MEM register: captures every cycle, only flush/reset clear it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_mem <= '0;
      zero_mem   <= 1'b0;
    end else if (flush) begin
      result_mem <= '0;
      zero_mem   <= 1'b0;
    end else begin
      result_mem <= alu_out_ex;
      zero_mem   <= zero_ex;
    end
  end

endmodule

// File: tb/tb_decode_exec_unit.sv
// Self-checking bench for decode_exec_unit: per-cycle stimulus with
// expected EX controls and EX/MEM results held in scoreboard queues.
module tb_decode_exec_unit;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic [3:0] aluctl;
  } ex_exp_t;

  typedef struct packed {
    logic        zero;
    logic [31:0] result;
  } mem_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic        branch_eq;
  logic        branch_ne;
  logic        jump;
  logic        regdst_ex;
  logic        alusrc_ex;
  logic        memread_ex;
  logic        memwrite_ex;
  logic        memtoreg_ex;
  logic        regwrite_ex;
  logic [3:0]  aluctl_ex;
  logic [31:0] alu_out_ex;
  logic [31:0] result_mem;
  logic        zero_mem;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ex_exp_t  ex_q[$];
  mem_exp_t mem_q[$];
  logic [3:0] cur_aluctl;

  always #5 clk = ~clk;

  decode_exec_unit #(
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .opcode      (opcode),
    .funct       (funct),
    .a           (a),
    .b           (b),
    .c           (c),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .jump        (jump),
    .regdst_ex   (regdst_ex),
    .alusrc_ex   (alusrc_ex),
    .memread_ex  (memread_ex),
    .memwrite_ex (memwrite_ex),
    .memtoreg_ex (memtoreg_ex),
    .regwrite_ex (regwrite_ex),
    .aluctl_ex   (aluctl_ex),
    .alu_out_ex  (alu_out_ex),
    .result_mem  (result_mem),
    .zero_mem    (zero_mem)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_aluctl(input logic [1:0] aluop, input logic [5:0] fn);
    logic [3:0] r;
    r = 4'b1111;
    case (aluop)
      2'b00: r = 4'b0010;
      2'b01: r = 4'b0110;
      2'b10: begin
        case (fn)
          6'b100000: r = 4'b0010;
          6'b100010: r = 4'b0110;
          6'b100100: r = 4'b0000;
          6'b100101: r = 4'b0001;
          6'b101010: r = 4'b0111;
          6'b100111: r = 4'b1100;
          6'b100110: r = 4'b1101;
          6'b000011: r = 4'b0011;
          default:   r = 4'b1111;
        endcase
      end
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Expected EX-stage state after the edge that samples this ID input
  function automatic ex_exp_t ref_ex(input logic [5:0] op, input logic [5:0] fn,
                                     input logic st, input logic fl);
    ex_exp_t    e;
    logic [1:0] aluop;
    e     = '0;
    aluop = 2'b00;
    if (fl || st) begin
      e.aluctl = 4'b0010;
      return e;
    end
    case (op)
      6'b000000: begin e.regdst = 1'b1; e.regwrite = 1'b1; aluop = 2'b10; end
      6'b100011: begin e.alusrc = 1'b1; e.memread = 1'b1; e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      6'b101011: begin e.alusrc = 1'b1; e.memwrite = 1'b1; end
      6'b001000: begin e.alusrc = 1'b1; e.regwrite = 1'b1; end
      6'b000100: aluop = 2'b01;
      6'b000101: aluop = 2'b01;
      default:   aluop = 2'b00;
    endcase
    e.aluctl = ref_aluctl(aluop, fn);
    return e;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] z);
    logic [31:0] r;
    case (ctl)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0011: r = x + y + z;
      4'b0110: r = x - y;
      4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(x | y);
      4'b1101: r = x ^ y;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // One pipeline cycle; called at a negedge, returns at the next negedge.
  // op/fn enter ID; av/bv/cv are operands for the instruction now in EX.
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic st,
                     input logic fl, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] cv);
    ex_exp_t     e;
    mem_exp_t    m;
    logic [31:0] r;
    opcode = op;
    funct  = fn;
    stall  = st;
    flush  = fl;
    a      = av;
    b      = bv;
    c      = cv;
    #1;
    check("branch_eq", 32'(branch_eq), 32'(op == 6'b000100));
    check("branch_ne", 32'(branch_ne), 32'(op == 6'b000101));
    check("jump", 32'(jump), 32'(op == 6'b000010));
    r = ref_alu(cur_aluctl, av, bv, cv);
    check("alu_out_ex", alu_out_ex, r);
    ex_q.push_back(ref_ex(op, fn, st, fl));
    m.result = fl ? 32'd0 : r;
    m.zero   = fl ? 1'b0 : (r == 32'd0);
    mem_q.push_back(m);
    @(posedge clk);
    #1;
    e = ex_q.pop_front();
    check("regdst_ex", 32'(regdst_ex), 32'(e.regdst));
    check("alusrc_ex", 32'(alusrc_ex), 32'(e.alusrc));
    check("memread_ex", 32'(memread_ex), 32'(e.memread));
    check("memwrite_ex", 32'(memwrite_ex), 32'(e.memwrite));
    check("memtoreg_ex", 32'(memtoreg_ex), 32'(e.memtoreg));
    check("regwrite_ex", 32'(regwrite_ex), 32'(e.regwrite));
    check("aluctl_ex", 32'(aluctl_ex), 32'(e.aluctl));
    cur_aluctl = e.aluctl;
    m = mem_q.pop_front();
    check("result_mem", result_mem, m.result);
    check("zero_mem", 32'(zero_mem), 32'(m.zero));
    @(negedge clk);
  endtask

  task automatic check_regs_clear(input string tag);
    check({tag, ".regdst_ex"}, 32'(regdst_ex), 32'd0);
    check({tag, ".alusrc_ex"}, 32'(alusrc_ex), 32'd0);
    check({tag, ".memread_ex"}, 32'(memread_ex), 32'd0);
    check({tag, ".memwrite_ex"}, 32'(memwrite_ex), 32'd0);
    check({tag, ".memtoreg_ex"}, 32'(memtoreg_ex), 32'd0);
    check({tag, ".regwrite_ex"}, 32'(regwrite_ex), 32'd0);
    check({tag, ".aluctl_ex"}, 32'(aluctl_ex), 32'(4'b0010));
    check({tag, ".result_mem"}, result_mem, 32'd0);
    check({tag, ".zero_mem"}, 32'(zero_mem), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    opcode = 6'b000000;
    funct  = 6'b000000;
    a      = 32'd0;
    b      = 32'd0;
    c      = 32'd0;
    cur_aluctl = 4'b0010;
    #3;
    check_regs_clear("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //  opcode     funct     st    fl    a             b             c
    cyc(6'b000000, 6'b100000, 1'b0, 1'b0, 32'd0,        32'd0,        32'd0);  // add; EX idle
    cyc(6'b000100, 6'b000000, 1'b0, 1'b0, 32'd5,        32'd7,        32'd0);  // beq; add 5+7
    cyc(6'b000000, 6'b101010, 1'b0, 1'b0, 32'h1234,     32'h1234,     32'd0);  // slt; beq equal
    cyc(6'b000000, 6'b100000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0);  // add; slt -1<1
    cyc(6'b000000, 6'b000011, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0);  // add3; add wraps
    cyc(6'b000000, 6'b100100, 1'b0, 1'b0, 32'd1,        32'd2,        32'd3);  // and; add3
    cyc(6'b000000, 6'b100101, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd9);  // or; and
    cyc(6'b000000, 6'b100111, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0);  // nor; or
    cyc(6'b000000, 6'b100110, 1'b0, 1'b0, 32'h00FF0000, 32'h0000FF00, 32'd0);  // xor; nor
    cyc(6'b000000, 6'b100010, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A0000, 32'd0);  // sub; xor
    cyc(6'b000000, 6'b101010, 1'b0, 1'b0, 32'd3,        32'd10,       32'd0);  // slt; sub wraps
    cyc(6'b000000, 6'b111111, 1'b0, 1'b0, 32'd1,        32'h80000000, 32'd0);  // bad funct; slt 1<min
    cyc(6'b000101, 6'b100000, 1'b0, 1'b0, 32'd77,       32'd88,       32'd0);  // bne; bad funct -> 0
    cyc(6'b100011, 6'b000000, 1'b0, 1'b0, 32'd9,        32'd4,        32'd0);  // lw; bne sub
    cyc(6'b101011, 6'b000000, 1'b1, 1'b0, 32'h100,      32'h20,       32'd0);  // stall; lw add
    cyc(6'b001000, 6'b000000, 1'b0, 1'b0, 32'd6,        32'd6,        32'd0);  // addi; bubble add
    cyc(6'b000010, 6'b000000, 1'b0, 1'b0, 32'd40,       32'd2,        32'd0);  // j; addi add
    cyc(6'b111111, 6'b100000, 1'b0, 1'b0, 32'd3,        32'd4,        32'd0);  // bad op; j add
    cyc(6'b101011, 6'b000000, 1'b0, 1'b0, 32'd8,        32'd8,        32'd0);  // sw; bad op add
    cyc(6'b100011, 6'b000000, 1'b0, 1'b1, 32'd11,       32'd22,       32'd0);  // flush with lw
    cyc(6'b000000, 6'b000011, 1'b0, 1'b0, 32'd4,        32'd5,        32'd0);  // add3; flushed add
    cyc(6'b100011, 6'b000000, 1'b0, 1'b0, 32'd10,       32'd20,       32'd30); // lw; add3

    // Asynchronous reset while lw sits in EX with a live result in EX/MEM
    rst_n = 1'b0;
    #1;
    check_regs_clear("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    cur_aluctl = 4'b0010;

    cyc(6'b000000, 6'b100010, 1'b0, 1'b0, 32'd2,        32'd3,        32'd0);  // sub; idle add
    cyc(6'b000000, 6'b100000, 1'b0, 1'b0, 32'd50,       32'd8,        32'd0);  // add; sub
    cyc(6'b000000, 6'b100000, 1'b0, 1'b0, 32'd1,        32'd1,        32'd0);  // add; add

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
